// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the main-memory responder.
//   WORD_W           width of one backing-store word
//   DEF_LINE_WORDS   default words per cache line
//   DEF_DEPTH_WORDS  default backing-store depth in words
//   DEF_LATENCY      default access latency in cycles
//   state_e          responder FSM states
package mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LATENCY     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    WDONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_array.sv
// sram_array: backing store for the responder.
// Synchronous line-wide write, asynchronous single-word read. Contents are
// never reset.
// Ports:
//   clk        clock, rising edge
//   wr_en_i    write the whole line addressed by wr_line_i this edge
//   wr_line_i  line index (word index without the in-line offset bits)
//   wr_data_i  line data, word 0 in the LSBs
//   rd_addr_i  word index for the combinational read port
//   rd_data_o  read data
module sram_array
  import mem_pkg::*;
#(
  parameter int  LINE_WORDS  = DEF_LINE_WORDS,
  parameter int  DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int AW          = $clog2(DEPTH_WORDS),
  localparam int OW          = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [AW-OW-1:0]             wr_line_i,
  input  logic [WORD_W*LINE_WORDS-1:0] wr_data_i,
  input  logic [AW-1:0]                rd_addr_i,
  output logic [WORD_W-1:0]            rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        mem_q[{wr_line_i, i[OW-1:0]}] <= wr_data_i[i*WORD_W +: WORD_W];
      end
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency main-memory model answering cache line
// refills (burst of LINE_WORDS beats) and line writebacks (single wr_done
// pulse). One transaction at a time; no request queuing.
// Optional feature macro: MEM_BOUNDS_CHECK_EN -- when defined, a request whose
// word index is >= DEPTH_WORDS returns zero data with resp_err on every beat,
// or raises resp_err with wr_done and skips the write. When undefined the
// word index wraps modulo DEPTH_WORDS and resp_err is always 0.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_write         1 = writeback, 0 = refill
//   req_addr          byte address, in-line offset bits ignored
//   req_wdata         writeback line, word 0 in the LSBs
//   resp_valid/ready  refill beat handshake
//   resp_data         refill beat data
//   resp_last         final beat of the line
//   wr_done           one-cycle pulse when a writeback commits
//   resp_err          error flag, qualified by resp_valid or wr_done
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [31:0]                  req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WORD_W-1:0]            resp_data,
  output logic                         resp_last,
  output logic                         wr_done,
  output logic                         resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int CW = 4;

  state_e                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [OW-1:0]               beat_q;
  logic                        write_q;
  logic                        oob_q;
  logic                        req_ready_q;
  logic                        resp_valid_q;
  logic                        resp_last_q;
  logic                        wr_done_q;
  logic                        resp_err_q;
  logic [AW-OW-1:0]            line_q;
  logic [WORD_W*LINE_WORDS-1:0] wdata_q;
  logic [WORD_W-1:0]           resp_data_q;

  logic                        oob_w;
  logic                        accept;
  logic                        wait_done;
  logic                        ld_beat;
  logic                        wr_en;
  logic [OW-1:0]               beat_d;
  logic [AW-1:0]               rd_addr;
  logic [WORD_W-1:0]           rd_data;

  // Offset bits inside the line never select anything.
  logic unused_offset_bits;
  assign unused_offset_bits = ^req_addr[OW+1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_w = |req_addr[31:AW+2];
`else
  logic unused_high_bits;
  assign unused_high_bits = ^req_addr[31:AW+2];
  assign oob_w = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && req_valid;
  assign wait_done = (state_q == WAIT) && (cnt_q == '0);

  // Output register reload: first beat as WAIT expires, later beats on each
  // accepted non-final beat.
  assign ld_beat = (wait_done && !write_q) ||
                   ((state_q == BURST) && resp_ready && !resp_last_q);

  // The line is written on the edge that enters WDONE.
  assign wr_en = wait_done && write_q && !oob_q;

  // Word offset of the beat about to be loaded into the output register.
  assign beat_d  = (state_q == BURST) ? beat_q + 1'b1 : '0;
  assign rd_addr = {line_q, beat_d};

  sram_array #(
    .LINE_WORDS (LINE_WORDS),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_line_i (line_q),
    .wr_data_i (wdata_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      write_q      <= 1'b0;
      oob_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      wr_done_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= WAIT;
            cnt_q       <= CW'(LATENCY - 1);
            write_q     <= req_write;
            oob_q       <= oob_w;
            req_ready_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (write_q) begin
            state_q    <= WDONE;
            wr_done_q  <= 1'b1;
            resp_err_q <= oob_q;
          end else begin
            state_q      <= BURST;
            beat_q       <= '0;
            resp_valid_q <= 1'b1;
            resp_last_q  <= (LINE_WORDS == 1);
            resp_err_q   <= oob_q;
          end
        end
        BURST: begin
          if (resp_ready) begin
            if (resp_last_q) begin
              state_q      <= IDLE;
              beat_q       <= '0;
              req_ready_q  <= 1'b1;
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              resp_err_q   <= 1'b0;
            end else begin
              beat_q      <= beat_q + 1'b1;
              resp_last_q <= (beat_q == OW'(LINE_WORDS - 2));
            end
          end
        end
        WDONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          wr_done_q   <= 1'b0;
          resp_err_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Datapath registers, not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q  <= req_addr[AW+1:OW+2];
      wdata_q <= req_wdata;
    end
    if (ld_beat) begin
      resp_data_q <= oob_q ? '0 : rd_data;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign wr_done    = wr_done_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Testbench for main_mem_responder: directed steps plus randomized traffic,
// checked against a word-array model of the backing store.
module tb_main_mem_responder;

  localparam int LW    = 4;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [32*LW-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_last;
  logic              wr_done;
  logic              resp_err;

  always #5 clk = ~clk;

  main_mem_responder #(
    .LINE_WORDS (LW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_last (resp_last),
    .wr_done   (wr_done),
    .resp_err  (resp_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_m [DEPTH];
  bit          bounds_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: word index wraps modulo the depth; lines are aligned.
  function automatic int unsigned line_base(input logic [31:0] a);
    return (((a >> 2) % DEPTH) / LW) * LW;
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return bounds_en && ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [32*LW-1:0] rnd_line();
    logic [32*LW-1:0] v;
    for (int i = 0; i < LW; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete transaction from the current sample point (#1 after an edge).
  // rmode: 0 = resp_ready always 1, 1 = pattern 1,0,0,..., 2 = random.
  // hold keeps req_valid asserted afterwards; waited reports cycles spent
  // before the request was accepted.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [32*LW-1:0] wd,
                     input int rmode, input bit hold, output int waited);
    int unsigned base;
    bit          oob;
    int          beat;
    int          guard;
    bit          r;
    base = line_base(addr);
    oob  = is_oob(addr);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("req_ready_wait", req_ready, 1);
    tick();
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) tick();
      if (wr) chk("wr_done_latency", wr_done, (k == LAT + 1));
      else    chk("resp_valid_latency", resp_valid, (k == LAT + 1));
      if (k <= LAT) chk("req_ready_busy", req_ready, 0);
    end
    if (wr) begin
      chk("wr_err", resp_err, oob);
      if (!oob) for (int i = 0; i < LW; i++) mem_m[base + i] = wd[i*32 +: 32];
      tick();
      chk("wr_done_single_pulse", wr_done, 0);
      chk("req_ready_after_wr", req_ready, 1);
    end else begin
      beat  = 0;
      guard = 0;
      while (beat < LW && guard < 200) begin
        chk("beat_valid", resp_valid, 1);
        chk("beat_data", resp_data, oob ? 32'h0 : mem_m[base + beat]);
        chk("beat_last", resp_last, (beat == LW - 1));
        chk("beat_err", resp_err, oob);
        chk("req_ready_burst", req_ready, 0);
        case (rmode)
          0:       r = 1'b1;
          1:       r = (guard % 3 == 0);
          default: r = 1'($urandom);
        endcase
        resp_ready = r;
        tick();
        if (r) beat++;
        guard++;
      end
      resp_ready = 1'b0;
      chk("beat_count", beat, LW);
      chk("resp_valid_after_last", resp_valid, 0);
      chk("req_ready_after_last", req_ready, 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_last"}, resp_last, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [32*LW-1:0] line;
`ifdef MEM_BOUNDS_CHECK_EN
    bounds_en = 1'b1;
`else
    bounds_en = 1'b0;
`endif
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk_reset_outputs("post_reset");

    // Give every word a known value.
    for (int l = 0; l < DEPTH / LW; l++) txn(1'b1, 32'(l * LW * 4), rnd_line(), 0, 1'b0, w);

    // Refill of a known line with a free-running consumer.
    txn(1'b1, 32'h40, 128'h00000044_00000033_00000022_00000011, 0, 1'b0, w);
    txn(1'b0, 32'h40, '0, 0, 1'b0, w);
    // Stalling consumer.
    txn(1'b0, 32'h40, '0, 1, 1'b0, w);
    // Writeback then immediate refill of the same line.
    txn(1'b1, 32'h80, 128'h0000000D_0000000C_0000000B_0000000A, 0, 1'b0, w);
    txn(1'b0, 32'h80, '0, 0, 1'b0, w);
    chk("wb_readback_word0", mem_m[32], 32'hA);
    // Unaligned address inside the line.
    txn(1'b0, 32'h8C, '0, 2, 1'b0, w);

    // Reset during beat 2 of a refill.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    tick();
    req_valid = 1'b0;
    repeat (LAT) tick();
    chk("mid_burst_valid", resp_valid, 1);
    resp_ready = 1'b1;
    repeat (2) tick();
    resp_ready = 1'b0;
    chk("mid_burst_beat2", resp_data, 32'h33);
    reset = 1'b1;
    #1;
    chk_reset_outputs("burst_reset");
    tick();
    reset = 1'b0;
    txn(1'b0, 32'h40, '0, 0, 1'b0, w);

    // Reset during the wait of a writeback: memory must keep the old line.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h80;
    req_wdata = 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk_reset_outputs("wait_reset");
    tick();
    reset = 1'b0;
    txn(1'b0, 32'h80, '0, 0, 1'b0, w);

    // Address one past the end of the store.
    txn(1'b0, 32'h1000, '0, 0, 1'b0, w);
    txn(1'b1, 32'h1010, rnd_line(), 0, 1'b0, w);
    txn(1'b0, 32'h10, '0, 0, 1'b0, w);

    // req_valid held high across a refill.
    txn(1'b0, 32'h40, '0, 2, 1'b1, w);
    txn(1'b0, 32'h80, '0, 0, 1'b0, w);
    chk("held_req_first_idle", w, 0);

    // Random traffic, including addresses past the end of the store.
    for (int n = 0; n < 80; n++) begin
      line = rnd_line();
      txn(1'($urandom), $urandom_range(0, DEPTH * 8 - 1), line, 2, 1'b0, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
